// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel enable, DrawX/DrawY counters, delayed sync/blank, frame pulse.
// Optional frame counter port/register enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic        pixel_clk,
  output logic        pix_en,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank_n,
  output logic        sync_n,
  output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  // Strobe bundle order {hs, vs, blank_n}; idle value is sync high, blanked.
  localparam logic [2:0] STROBE_IDLE = 3'b110;

  logic       pix_en_q;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       frame_wrap_q;
  logic       frame_start_q;
  logic       x_last, y_last;
  logic [2:0] strobe_raw;

  assign x_last = (x_q == H_LAST);
  assign y_last = (y_q == V_LAST);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_en_q) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // frame_wrap_q marks the edge that returned both counters to 0; frame_start
  // follows one Clk later, so the post-reset (0,0) never produces a pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_en_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_wrap_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_en_q      <= ~pix_en_q;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_wrap_q  <= pix_en_q & x_last & y_last;
      frame_start_q <= frame_wrap_q;
    end
  end

  assign strobe_raw[2] = ~((x_q >= HS_BEG) && (x_q < HS_END));
  assign strobe_raw[1] = ~((y_q >= VS_BEG) && (y_q < VS_END));
  assign strobe_raw[0] = (x_q < H_VIS) && (y_q < V_VIS);

  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign {hs, vs, blank_n} = strobe_raw;
    end else begin : g_dly
      logic [SYNC_DELAY-1:0][2:0] pipe_q;

      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          pipe_q <= {SYNC_DELAY{STROBE_IDLE}};
        end else begin
          pipe_q[0] <= strobe_raw;
          for (int i = 1; i < int'(SYNC_DELAY); i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign {hs, vs, blank_n} = pipe_q[SYNC_DELAY-1];
    end
  endgenerate

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)          frame_cnt_q <= '0;
    else if (frame_wrap_q) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_count = frame_cnt_q;
`endif

  assign pix_en      = pix_en_q;
  assign pixel_clk   = pix_en_q;
  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign frame_start = frame_start_q;
  assign sync_n      = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default horizontal timing, short frame height so whole frames fit.
module tb_vga_timing_gen;
  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int SD = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       pixel_clk, pix_en, hs, vs, blank_n, sync_n, frame_start;
  logic [9:0] DrawX, DrawY;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_DELAY(SD)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pixel_clk(pixel_clk), .pix_en(pix_en),
    .DrawX(DrawX), .DrawY(DrawY), .hs(hs), .vs(vs), .blank_n(blank_n),
    .sync_n(sync_n), .frame_start(frame_start)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  always #10 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int n = 0;
  logic [26:0] obs;
  localparam logic [26:0] RST_VEC = {1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  assign obs = {pix_en, pixel_clk, DrawX, DrawY, hs, vs, blank_n, sync_n, frame_start};

  // Undelayed strobes at step m: each pixel holds for two steps.
  function automatic logic [2:0] raw_at(int m);
    int pos, x, y;
    logic h, v, b;
    pos = (m / 2) % FT;
    x = pos % HT;
    y = pos / HT;
    h = !(x >= HV + HF && x < HV + HF + HS);
    v = !(y >= VV + VF && y < VV + VF + VS);
    b = (x < HV) && (y < VV);
    return {h, v, b};
  endfunction

  // Expected outputs k Clk edges after reset release.
  function automatic logic [26:0] exp_at(int k);
    logic [2:0] s;
    logic fs, p;
    int pos;
    pos = (k / 2) % FT;
    p = (k % 2) == 1;
    s = (k >= SD) ? raw_at(k - SD) : 3'b110;
    fs = (k >= 3) && ((k - 1) % 2 == 0) && (((k - 1) / 2) % FT == 0);
    return {p, p, 10'(pos % HT), 10'(pos / HT), s, 1'b0, fs};
  endfunction

  task automatic test_reset();
    Reset_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      checks++;
      if (obs !== RST_VEC) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, obs, RST_VEC);
      end
    end
    Reset_n = 1'b1;
    n = 0;
    #1;
    checks++;
    if (obs !== exp_at(0)) begin
      errors++;
      $display("FAIL reset_release got=%h want=%h", obs, exp_at(0));
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); n++; @(negedge Clk);
      checks++;
      if (obs !== exp_at(n)) begin
        errors++;
        $display("FAIL post_reset n=%0d got=%h want=%h", n, obs, exp_at(n));
      end
      if (n == 2) begin
        checks++;
        if (DrawX !== 10'd1) begin
          errors++;
          $display("FAIL drawx_second_edge got=%0d want=1", DrawX);
        end
      end
    end
  endtask

  task automatic test_line();
    int t656 = -1, tfall = -1, trise = -1, t640 = -1, tbfall = -1;
    int px, py;
    logic ph, pb;
    bit wrap_seen = 0;
    for (int i = 0; i < 1700; i++) begin
      px = DrawX; py = DrawY; ph = hs; pb = blank_n;
      @(posedge Clk); n++; @(negedge Clk);
      checks++;
      if (obs !== exp_at(n)) begin
        errors++;
        $display("FAIL line_model n=%0d got=%h want=%h", n, obs, exp_at(n));
      end
      if (t656 < 0 && DrawX == 10'd656) t656 = n;
      if (t640 < 0 && DrawX == 10'd640) t640 = n;
      if (tfall < 0 && ph && !hs) tfall = n;
      if (tfall >= 0 && trise < 0 && !ph && hs) trise = n;
      if (tbfall < 0 && pb && !blank_n) tbfall = n;
      if (px == HT - 1 && DrawX == 10'd0 && !wrap_seen) begin
        wrap_seen = 1;
        checks++;
        if (DrawY !== 10'(py + 1)) begin
          errors++;
          $display("FAIL line_wrap_y got=%0d want=%0d", DrawY, py + 1);
        end
      end
    end
    checks++;
    if (!wrap_seen) begin
      errors++;
      $display("FAIL line_wrap_seen got=0 want=1");
    end
    checks++;
    if (t656 < 0 || tfall - t656 != SD) begin
      errors++;
      $display("FAIL hs_fall_delay got=%0d want=%0d", tfall - t656, SD);
    end
    checks++;
    if (tfall < 0 || trise - tfall != 2 * HS) begin
      errors++;
      $display("FAIL hs_low_width got=%0d want=%0d", trise - tfall, 2 * HS);
    end
    checks++;
    if (t640 < 0 || tbfall - t640 != SD) begin
      errors++;
      $display("FAIL blank_fall_delay got=%0d want=%0d", tbfall - t640, SD);
    end
  endtask

  task automatic test_frame();
    bit found = 0;
    int len = 0, vs_low = 0, blank_hi = 0;
    for (int i = 0; i < 3 * FT && !found; i++) begin
      @(posedge Clk); n++; @(negedge Clk);
      checks++;
      if (obs !== exp_at(n)) begin
        errors++;
        $display("FAIL frame_wait_model n=%0d got=%h want=%h", n, obs, exp_at(n));
      end
      if (frame_start) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL frame_start_timeout got=none want=pulse");
      return;
    end
    found = 0;
    for (int i = 0; i < 2 * FT + 10 && !found; i++) begin
      if (!vs) vs_low++;
      if (blank_n) blank_hi++;
      @(posedge Clk); n++; @(negedge Clk);
      len++;
      checks++;
      if (obs !== exp_at(n)) begin
        errors++;
        $display("FAIL frame_model n=%0d got=%h want=%h", n, obs, exp_at(n));
      end
      if (frame_start) found = 1;
    end
    checks++;
    if (len != 2 * FT) begin
      errors++;
      $display("FAIL frame_period got=%0d want=%0d", len, 2 * FT);
    end
    checks++;
    if (vs_low != 2 * VS * HT) begin
      errors++;
      $display("FAIL vs_low_cycles got=%0d want=%0d", vs_low, 2 * VS * HT);
    end
    checks++;
    if (blank_hi != 2 * HV * VV) begin
      errors++;
      $display("FAIL blank_high_cycles got=%0d want=%0d", blank_hi, 2 * HV * VV);
    end
`ifdef VGA_FRAME_COUNT_EN
    checks++;
    if (frame_count !== 16'((n - 1) / (2 * FT))) begin
      errors++;
      $display("FAIL frame_count got=%0d want=%0d", frame_count, (n - 1) / (2 * FT));
    end
`endif
  endtask

  task automatic test_mid_reset();
    int run_len, hold;
    run_len = 100 + int'($urandom_range(3000));
    hold = 1 + int'($urandom_range(5));
    for (int i = 0; i < run_len; i++) begin
      @(posedge Clk); n++; @(negedge Clk);
      checks++;
      if (obs !== exp_at(n)) begin
        errors++;
        $display("FAIL pre_reset_model n=%0d got=%h want=%h", n, obs, exp_at(n));
      end
    end
    @(posedge Clk);
    #5 Reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== RST_VEC) begin
      errors++;
      $display("FAIL async_reset got=%h want=%h", obs, RST_VEC);
    end
`ifdef VGA_FRAME_COUNT_EN
    checks++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL frame_count_reset got=%0d want=0", frame_count);
    end
`endif
    for (int i = 0; i < hold; i++) @(negedge Clk);
    Reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge Clk); n++; @(negedge Clk);
      checks++;
      if (obs !== exp_at(n)) begin
        errors++;
        $display("FAIL post_reset_model n=%0d got=%h want=%h", n, obs, exp_at(n));
      end
    end
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
